// File: rtl/req_encoder_pkg.sv
// rtl/req_encoder_pkg.sv - shared types and constants for the 16-line request encoder
package enc_pkg;

  localparam int N_LINES = 16;
  localparam int CODE_W  = 4;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [N_LINES-1:0] lines_t;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  function automatic lines_t onehot(code_t c);
    return lines_t'(1) << c;
  endfunction

endpackage

// File: rtl/req_encoder_if.sv
// rtl/req_encoder_if.sv - valid/ready code channel between encoder (master) and consumer (slave)
interface req_encoder_if;
  import enc_pkg::*;

  logic  valid;
  logic  ready;
  code_t code;

  modport master (output valid, output code, input ready);
  modport slave  (input valid, input code, output ready);

endinterface

// File: rtl/req_encoder_prio_pick.sv
// rtl/req_encoder_prio_pick.sv - find-first-set over 16 lines, search starting at a rotating offset
module prio_pick
  import enc_pkg::*;
(
  input  lines_t req,
  input  code_t  start,
  output logic   found,
  output code_t  idx
);

  code_t j;

  // Scan from farthest to nearest so the nearest set bit to start is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      j = start + code_t'(k);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - 16-line active-low request encoder with valid/ready code output.
// ENCODER_RR_EN selects round-robin instead of lowest-index priority.
module req_encoder
  import enc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  lines_t          req_n,
  input  logic            enable,
  req_encoder_if.master   bus,
  output logic            drop
);

  state_t state_q;
  lines_t req_n_q, pending_q, pending_d;
  lines_t fall, clr;
  logic   valid_q, drop_q;
  code_t  code_q, sel, start;
  logic   found, load;

`ifdef ENCODER_RR_EN
  code_t last_q;
  assign start = last_q + code_t'(1);
`else
  assign start = '0;
`endif

  prio_pick u_pick (
    .req   (pending_q),
    .start (start),
    .found (found),
    .idx   (sel)
  );

  assign fall      = req_n_q & ~req_n & {N_LINES{enable}};
  assign load      = found && ((state_q == IDLE) || bus.ready);
  assign clr       = load ? onehot(sel) : '0;
  // A fresh edge on the line being loaded re-pends it rather than counting as a drop.
  assign pending_d = (pending_q & ~clr) | fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_n_q   <= '1;
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      drop_q    <= 1'b0;
`ifdef ENCODER_RR_EN
      last_q    <= code_t'(N_LINES - 1);
`endif
    end else begin
      req_n_q   <= req_n;
      pending_q <= pending_d;
      drop_q    <= |(fall & pending_q & ~clr);
`ifdef ENCODER_RR_EN
      if (load) last_q <= sel;
`endif
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= PRESENT;
            valid_q <= 1'b1;
            code_q  <= sel;
          end
        end
        PRESENT: begin
          if (bus.ready) begin
            if (load) begin
              code_q <= sel;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.code  = code_q;
  assign drop      = drop_q;

endmodule
